// File: rtl/control_fsm_if.sv
// Controller <-> datapath bundle: instruction/flags in, datapath enables and selects out.
// master = controller side, slave = datapath side.
interface control_fsm_if #(
   parameter int SIZE = 16
);
   logic [SIZE-1:0] instr;
   logic [1:0]      flags1;
   logic [2:0]      flags2;
   logic            MemW1e;
   logic            MemW2e;
   logic            RegWe;
   logic            psr_en;
   logic            pc_en;
   logic            ir_en;
   logic            Movm;
   logic [1:0]      RWm;
   logic [1:0]      PCm;
   logic [1:0]      A2m;
   logic [1:0]      LUIm;
   logic [3:0]      AluOp;
   logic            halted;
   logic [2:0]      state;

   modport master (
      input  instr, flags1, flags2,
      output MemW1e, MemW2e, RegWe, psr_en, pc_en, ir_en, Movm,
             RWm, PCm, A2m, LUIm, AluOp, halted, state
   );

   modport slave (
      output instr, flags1, flags2,
      input  MemW1e, MemW2e, RegWe, psr_en, pc_en, ir_en, Movm,
             RWm, PCm, A2m, LUIm, AluOp, halted, state
   );
endinterface

// File: rtl/control_fsm.sv
// Multicycle FETCH/DECODE/EXEC/LOAD_WB controller for the CR16-subset datapath.
// Define CTRL_ILLEGAL_TRAP_EN to halt on undefined instructions; otherwise they execute as NOPs.
module control_fsm #(
   parameter int SIZE = 16
) (
   input logic           clk,
   input logic           reset,
   control_fsm_if.master bus
);
   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_EXEC    = 3'd2;
   localparam logic [2:0] S_LOAD_WB = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   localparam logic [3:0] C_AND = 4'b0001;
   localparam logic [3:0] C_OR  = 4'b0010;
   localparam logic [3:0] C_XOR = 4'b0011;
   localparam logic [3:0] C_ADD = 4'b0101;
   localparam logic [3:0] C_SUB = 4'b1001;
   localparam logic [3:0] C_CMP = 4'b1011;
   localparam logic [3:0] C_MOV = 4'b1101;

   logic [2:0] state_reg, state_next;
   logic [3:0] op, ext, cond, code;
   logic       alu_valid, taken, illegal;
   logic [3:0] alu_sel;
   logic       mem_w2e, reg_we, psr_en, pc_en, ir_en, movm;
   logic [1:0] rwm, pcm, a2m, luim;
   logic [3:0] alu_op;

   assign op   = bus.instr[SIZE-1 -: 4];
   assign cond = bus.instr[11:8];
   assign ext  = bus.instr[7:4];
   // Register forms carry the operation in ext, immediate forms in the opcode itself.
   assign code = (op == 4'b0000) ? ext : op;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= S_FETCH;
      else        state_reg <= state_next;
   end

   always_comb begin
      alu_valid = 1'b1;
      alu_sel   = 4'd0;
      case (code)
         C_ADD:   alu_sel = 4'd0;
         C_SUB:   alu_sel = 4'd1;
         C_AND:   alu_sel = 4'd2;
         C_OR:    alu_sel = 4'd3;
         C_XOR:   alu_sel = 4'd4;
         C_CMP:   alu_sel = 4'd5;
         C_MOV:   alu_sel = 4'd7;
         default: alu_valid = 1'b0;
      endcase
   end

   // flags1 = {C, F}, flags2 = {L, Z, N}
   always_comb begin
      case (cond)
         4'b0000: taken = bus.flags2[1];
         4'b0001: taken = !bus.flags2[1];
         4'b0010: taken = bus.flags1[1];
         4'b0011: taken = !bus.flags1[1];
         4'b0100: taken = bus.flags2[2];
         4'b0101: taken = !bus.flags2[2];
         4'b0110: taken = bus.flags2[0];
         4'b0111: taken = !bus.flags2[0];
         4'b1000: taken = bus.flags1[0];
         4'b1001: taken = !bus.flags1[0];
         4'b1110: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      illegal    = 1'b0;
      mem_w2e    = 1'b0;
      reg_we     = 1'b0;
      psr_en     = 1'b0;
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      movm       = 1'b0;
      rwm        = 2'd0;
      pcm        = 2'd0;
      a2m        = 2'd0;
      luim       = 2'd0;
      alu_op     = 4'd0;
      case (state_reg)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            ir_en      = 1'b1;
            state_next = S_EXEC;
         end
         S_EXEC: begin
            state_next = S_FETCH;
            if (alu_valid) begin
               reg_we = (code != C_CMP);
               psr_en = (code == C_ADD) || (code == C_SUB) || (code == C_CMP);
               rwm    = 2'd2;
               movm   = (code != C_MOV);
               a2m    = (op == 4'b0000) ? 2'd0 : 2'd2;
               alu_op = alu_sel;
               pc_en  = 1'b1;
            end else begin
               case (op)
                  4'b1111: begin
                     luim   = 2'd2;
                     a2m    = 2'd2;
                     alu_op = 4'd8;
                     reg_we = 1'b1;
                     rwm    = 2'd2;
                     movm   = 1'b1;
                     pc_en  = 1'b1;
                  end
                  4'b1000: begin
                     if (ext == 4'b0100 || ext[3:1] == 3'b000) begin
                        a2m    = (ext == 4'b0100) ? 2'd0 : 2'd1;
                        alu_op = 4'd6;
                        reg_we = 1'b1;
                        rwm    = 2'd2;
                        movm   = 1'b1;
                        pc_en  = 1'b1;
                     end else begin
                        illegal = 1'b1;
                     end
                  end
                  4'b0100: begin
                     case (ext)
                        4'b0000: state_next = S_LOAD_WB;
                        4'b0100: begin
                           mem_w2e = 1'b1;
                           pc_en   = 1'b1;
                        end
                        4'b1100: begin
                           alu_op = 4'd7;
                           pcm    = taken ? 2'd2 : 2'd0;
                           pc_en  = 1'b1;
                        end
                        4'b1000: begin
                           reg_we = 1'b1;
                           rwm    = 2'd1;
                           pcm    = 2'd2;
                           alu_op = 4'd7;
                           pc_en  = 1'b1;
                        end
                        default: illegal = 1'b1;
                     endcase
                  end
                  4'b1100: begin
                     pc_en = 1'b1;
                     if (taken) begin
                        luim = 2'd1;
                        a2m  = 2'd2;
                        pcm  = 2'd2;
                     end
                  end
                  default: illegal = 1'b1;
               endcase
            end
            if (illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_next = S_HALT;
`else
               pc_en = 1'b1;
`endif
            end
         end
         S_LOAD_WB: begin
            reg_we     = 1'b1;
            pc_en      = 1'b1;
            state_next = S_FETCH;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_HALT:   state_next = S_HALT;
`endif
         default:  state_next = S_FETCH;
      endcase
   end

   assign bus.MemW1e = 1'b0;
   assign bus.MemW2e = mem_w2e;
   assign bus.RegWe  = reg_we;
   assign bus.psr_en = psr_en;
   assign bus.pc_en  = pc_en;
   assign bus.ir_en  = ir_en;
   assign bus.Movm   = movm;
   assign bus.RWm    = rwm;
   assign bus.PCm    = pcm;
   assign bus.A2m    = a2m;
   assign bus.LUIm   = luim;
   assign bus.AluOp  = alu_op;
   assign bus.state  = state_reg;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign bus.halted = (state_reg == S_HALT);
`else
   assign bus.halted = 1'b0;
`endif
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle controller for the 16-bit CR16-subset CPU datapath. It decodes the latched instruction word and the PSR flag outputs, and drives every datapath control input: memory and register write enables, PSR enable, mux selects and ALU op. It also drives the PC and instruction-register load enables. It sits beside the datapath in the top level, consuming its `instr`, `flags1out` and `flags2out`.

## Interface
- `SIZE`, 16, instruction/data width; only 16 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `instr`  in  SIZE  instruction register contents.
- `flags1`  in  2  PSR {C, F}.
- `flags2`  in  3  PSR {L, Z, N}.
- `MemW1e`  out  1  port-1 write enable; always 0.
- `MemW2e`  out  1  port-2 write enable (STOR).
- `RegWe`  out  1  register-file write enable.
- `psr_en`  out  1  PSR load enable.
- `pc_en`  out  1  PC register load enable.
- `ir_en`  out  1  instruction register load enable.
- `Movm`  out  1  0 = A2 mux out, 1 = ALU out.
- `RWm`  out  2  writeback select: 0 = MemR2, 1 = nextPc, 2 = Mov mux.
- `PCm`  out  2  PC select: 0 = nextPc, 1 = RegR1, 2 = ALU out.
- `A2m`  out  2  ALU B select: 0 = RegR2, 1 = zero-extended instr[3:0], 2 = seImm.
- `LUIm`  out  2  ALU A select: 0 = RegR1, 1 = PC, 2 = constant 8.
- `AluOp`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 LSH, 7 PASSB, 8 SHL-by-A (LUI).
- `halted`  out  1  high in HALT.
- `state`  out  3  debug: current state encoding.

## Operation
- States:
  - FETCH=0: PC presented to port 1; no enables.
  - DECODE=1: `ir_en`=1.
  - EXEC=2.
  - LOAD_WB=3.
  - HALT=4.
- Transitions:
  - FETCH→DECODE→EXEC.
  - EXEC→LOAD_WB for LOAD, otherwise EXEC→FETCH.
  - LOAD_WB→FETCH.
  - HALT is absorbing until reset.
- Decode: opcode is instr[15:12], ext is instr[7:4], cond is instr[11:8].
- R-type (op 0000) and immediate forms (op = ext code, `A2m`=2) in EXEC:
  - `RegWe`=1, `RWm`=2, `Movm`=1, `pc_en`=1, `PCm`=0.
  - ext/op codes: ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011.
  - MOV/MOVI 1101: `Movm`=0, `AluOp`=7.
  - CMP/CMPI: `RegWe`=0.
  - `psr_en`=1 for ADD, SUB and CMP (register and immediate forms) only.
- LUI (op 1111): `LUIm`=2, `A2m`=2, `AluOp`=8; destination write as above.
- Shifts (op 1000): ext 0100 → LSH with `A2m`=0; ext 000x → LSHI with `A2m`=1.
- Op 0100 (memory and jumps):
  - ext 0000 LOAD: EXEC has no enables; LOAD_WB has `RegWe`=1, `RWm`=0, `pc_en`=1.
  - ext 0100 STOR: EXEC has `MemW2e`=1, `pc_en`=1.
  - ext 1100 Jcond: `AluOp`=7, `A2m`=0. Taken → `PCm`=2; not taken → `PCm`=0. `pc_en`=1.
  - ext 1000 JAL: `RegWe`=1, `RWm`=1 (link = nextPc into instr[11:8]), `PCm`=2, `AluOp`=7, `A2m`=0, `pc_en`=1.
- Bcond (op 1100): taken → `LUIm`=1, `A2m`=2, `AluOp`=0, `PCm`=2. Target = branch address + sext(instr[7:0]). `pc_en`=1.
- Condition codes:
  - EQ 0000 → Z.
  - NE 0001 → !Z.
  - CS 0010 → C.
  - CC 0011 → !C.
  - HI 0100 → L.
  - LS 0101 → !L.
  - GT 0110 → N.
  - LE 0111 → !N.
  - FS 1000 → F.
  - FC 1001 → !F.
  - UC 1110 → always.
  - All other codes → never taken.
- Flags are sampled combinationally in EXEC. A PSR update from the previous instruction is visible because that update completed before FETCH.
- Undefined opcode/ext: see Configuration.

## Timing
- Outputs are combinational from `state` and `instr`. `state` is registered.
- Latency:
  - 3 cycles: ALU, STOR, branches, jumps.
  - 4 cycles: LOAD.
- Exactly one `pc_en` pulse per instruction, in its final state.
- Reset (asserted, or asserted mid-instruction): `state`=FETCH immediately.
  - All enables 0, all selects 0, `AluOp`=0, `halted`=0.
  - No partial write can complete: an EXEC-cycle write is suppressed asynchronously.
- Simultaneous `RegWe` and `psr_en`: both take effect on the same edge.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an undefined instruction in EXEC asserts no enables and moves to HALT; `halted`=1 until reset.
- Undefined: the instruction is a NOP. EXEC asserts only `pc_en`=1, `PCm`=0, then returns to FETCH. `halted` is tied 0 and HALT is unreachable.

## Test plan
- Reset low mid-EXEC of ADD → `state`=0, `RegWe`=0 same cycle; release → FETCH, DECODE, EXEC sequence restarts.
- instr 0x0251 (ADD R2,R1) → EXEC: `RegWe`=1, `psr_en`=1, `AluOp`=0, `RWm`=2, `Movm`=1, `pc_en`=1; next state FETCH.
- instr 0x4305 (LOAD R3,[R5]) → EXEC no enables; LOAD_WB `RegWe`=1, `RWm`=0, `pc_en`=1; 4 cycles total.
- instr 0xC0FE (BEQ -2): Z=1 → `PCm`=2, `LUIm`=1, `A2m`=2; Z=0 → `PCm`=0.
- instr 0x4E84 (JAL R14,R4) → `RegWe`=1, `RWm`=1, `PCm`=2, `AluOp`=7.
- instr 0x7000 → with `CTRL_ILLEGAL_TRAP_EN`: HALT, `halted`=1, no `pc_en`. Without the macro: `pc_en`=1, `PCm`=0.
